// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared sizing helpers and the Q1.F scale type for the
//               autotune fixed-point divider / multiplier pair.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Default fraction width, which is also the divider's quotient format
  localparam int FP_FRACTION_WIDTH = 10;

  // Q1.F scale factor: one integer bit and F fraction bits, range [0,2)
  typedef logic [FP_FRACTION_WIDTH:0] fp_scale_t;

  // Integer operand width that remains once the fraction bits are removed
  function automatic int fp_int_width(input int width, input int frac);
    return width - frac;
  endfunction

  // Scale bits handled per working stage: ceil((F+1)/(NUM_STAGES-2)).
  // One cycle of the latency is the accept and one is the finalisation.
  function automatic int fp_bits_per_stage(input int frac, input int stages);
    return (frac + 1 + stages - 3) / (stages - 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_stage.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_stage
// Description : Combinational shift-add slice. For every set bit j of the
//               scale slice, adds operand << (base + j) to the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_stage #(
  parameter int INT_WIDTH = 32,
  parameter int ACC_W     = 43,
  parameter int BPS       = 2,
  parameter int SH_W      = 4
) (
  input  logic [ACC_W-1:0]     acc_i,
  input  logic [INT_WIDTH-1:0] operand_i,
  input  logic [BPS-1:0]       bits_i,
  input  logic [SH_W-1:0]      base_i,
  output logic [ACC_W-1:0]     acc_o
);

  // Sum the partial products selected by this slice of the scale factor
  always_comb begin
    acc_o = acc_i;
    for (int j = 0; j < BPS; j++) begin
      if (bits_i[j]) begin
        acc_o = acc_o + (ACC_W'(operand_i) << (int'(base_i) + j));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_mul.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul
// Description : Fixed-latency unsigned multiplier, integer x Q1.F scale.
//               NUM_STAGES-2 shift-add cycles consume the scale LSB first,
//               then a final cycle rounds/truncates and presents the result.
//               NUM_STAGES must be at least 3.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul
  import fp_pkg::*;
#(
  parameter int  WIDTH          = 42,
  parameter int  FRACTION_WIDTH = 10,
  parameter int  NUM_STAGES     = 8,
  parameter int  ROUND          = 0,
  localparam int INT_WIDTH      = fp_int_width(WIDTH, FRACTION_WIDTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [INT_WIDTH-1:0]    operand_in,
  input  logic [FRACTION_WIDTH:0] scale_in,
  input  logic                    err_in,
  input  logic                    valid_in,
  output logic [INT_WIDTH:0]      product_out,
  output logic                    valid_out,
  output logic                    err_out,
  output logic                    busy
);

  localparam int F      = FRACTION_WIDTH;
  localparam int ACC_W  = INT_WIDTH + F + 1;
  localparam int WORK   = NUM_STAGES - 2;
  localparam int BPS    = fp_bits_per_stage(F, NUM_STAGES);
  localparam int PAD_W  = WORK * BPS;
  localparam int SH_W   = $clog2(PAD_W + 1);
  localparam int CNT_W  = $clog2(NUM_STAGES - 1);

  logic [INT_WIDTH-1:0] op_q;
  logic [F:0]           scale_q;
  logic                 err_lat_q;
  logic [ACC_W-1:0]     acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 err_q;
  logic [INT_WIDTH:0]   prod_q;

  logic [PAD_W-1:0]     w_scale_pad;
  logic [SH_W-1:0]      w_base;
  logic [BPS-1:0]       w_chunk;
  logic [ACC_W-1:0]     w_acc_d;
  logic [ACC_W-1:0]     w_rounded;
  logic [INT_WIDTH:0]   w_result;
  logic                 w_unused_frac;

  // Zero-padding above bit F makes the short last slice add nothing extra
  assign w_scale_pad = PAD_W'(scale_q);
  assign w_base      = SH_W'(int'(cnt_q) * BPS);
  assign w_chunk     = BPS'(w_scale_pad >> w_base);

  fp_mul_stage #(
    .INT_WIDTH (INT_WIDTH),
    .ACC_W     (ACC_W),
    .BPS       (BPS),
    .SH_W      (SH_W)
  ) u_stage (
    .acc_i     (acc_q),
    .operand_i (op_q),
    .bits_i    (w_chunk),
    .base_i    (w_base),
    .acc_o     (w_acc_d)
  );

  generate
    if (ROUND != 0) begin : g_round
      assign w_rounded = acc_q + (ACC_W'(1) << (F - 1));
    end else begin : g_trunc
      assign w_rounded = acc_q;
    end
  endgenerate

  // The rounded sum cannot exceed ACC_W bits, so the top INT_WIDTH+1 bits
  // are the whole product
  assign w_result      = w_rounded[ACC_W-1:F];
  assign w_unused_frac = &{1'b0, w_rounded[F-1:0]};

  // Accept, iterate and finalise; reset aborts any operation in flight
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      op_q      <= '0;
      scale_q   <= '0;
      err_lat_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      prod_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!busy_q) begin
        if (valid_in) begin
          op_q      <= operand_in;
          scale_q   <= scale_in;
          err_lat_q <= err_in;
          acc_q     <= '0;
          cnt_q     <= '0;
          busy_q    <= 1'b1;
        end
      end else if (cnt_q == CNT_W'(WORK)) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
        err_q   <= err_lat_q;
        prod_q  <= err_lat_q ? '0 : w_result;
      end else begin
        acc_q <= w_acc_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign product_out = prod_q;
  assign valid_out   = valid_q;
  assign err_out     = err_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul
// Description : Scoreboard bench for fp_mul, truncating and rounding builds
//               driven with the same directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_mul;

  localparam int IW = 32;
  localparam int NS = 8;

  typedef struct {
    logic [IW:0] p;
    logic        e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] operand;
  logic [10:0]   scale;
  logic          err_i;
  logic          valid_in;

  logic [IW:0]   p0, p1;
  logic          v0, v1, e0, e1, b0, b1;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mul #(.ROUND(0)) u_dut (
    .clk_in(clk), .rst_in(rst), .operand_in(operand), .scale_in(scale),
    .err_in(err_i), .valid_in(valid_in), .product_out(p0),
    .valid_out(v0), .err_out(e0), .busy(b0)
  );

  fp_mul #(.ROUND(1)) u_dut_r (
    .clk_in(clk), .rst_in(rst), .operand_in(operand), .scale_in(scale),
    .err_in(err_i), .valid_in(valid_in), .product_out(p1),
    .valid_out(v1), .err_out(e1), .busy(b1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [IW:0] x0, input logic [IW:0] x1, input logic e);
    exp_t a, b;
    a.p = x0; a.e = e;
    b.p = x1; b.e = e;
    q0.push_back(a);
    q1.push_back(b);
  endtask

  // Wait (bounded) at negedges until the truncating instance shows a result
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!v0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!v0) chk({name, "_timeout"}, 64'(v0), 64'd1);
  endtask

  // Monitor: pop the scoreboard whenever a result strobe is presented
  always @(negedge clk) begin
    exp_t ex;
    if (!rst) begin
      if (v0) begin
        if (q0.size() == 0) chk("unexpected_valid_r0", 64'(v0), 64'd0);
        else begin
          ex = q0.pop_front();
          chk("product_r0", 64'(p0), 64'(ex.p));
          chk("err_r0", 64'(e0), 64'(ex.e));
        end
      end else chk("err_idle_r0", 64'(e0), 64'd0);
      if (v1) begin
        if (q1.size() == 0) chk("unexpected_valid_r1", 64'(v1), 64'd0);
        else begin
          ex = q1.pop_front();
          chk("product_r1", 64'(p1), 64'(ex.p));
          chk("err_r1", 64'(e1), 64'(ex.e));
        end
      end else chk("err_idle_r1", 64'(e1), 64'd0);
    end
  end

  // One operation with latency, busy-length and hold checks
  task automatic run_op(input logic [IW-1:0] op, input logic [10:0] sc, input logic e,
                        input logic [IW:0] x0, input logic [IW:0] x1);
    int lat, busyc;
    @(negedge clk);
    operand = op; scale = sc; err_i = e; valid_in = 1'b1;
    push(x0, x1, e);
    @(negedge clk);
    valid_in = 1'b0;
    err_i = 1'b0;
    lat = 0; busyc = 0;
    while (!v0 && lat < 30) begin
      if (b0) busyc++;
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(NS - 1));
    chk("busy_cycles", 64'(busyc), 64'(NS - 1));
    chk("busy_low_at_valid", 64'(b0), 64'd0);
    @(negedge clk);
    chk("valid_one_cycle", 64'(v0), 64'd0);
    chk("product_hold", 64'(p0), 64'(x0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second;
    rst = 1'b1; valid_in = 1'b0; operand = '0; scale = '0; err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(b0), 64'd0);
    chk("reset_valid", 64'(v0), 64'd0);
    chk("reset_product", 64'(p0), 64'd0);
    chk("reset_err", 64'(e0), 64'd0);
    rst = 1'b0;

    run_op(32'd100,        11'h400, 1'b0, 33'd100,        33'd100);
    run_op(32'd1000,       11'h200, 1'b0, 33'd500,        33'd500);
    run_op(32'd3,          11'h155, 1'b0, 33'd0,          33'd1);
    run_op(32'hFFFF_FFFF,  11'h7FF, 1'b0, 33'h1_FFBF_FFFE, 33'h1_FFBF_FFFE);
    run_op(32'd7,          11'h600, 1'b0, 33'd10,         33'd11);
    run_op(32'd0,          11'h7FF, 1'b0, 33'd0,          33'd0);
    run_op(32'd12345,      11'h000, 1'b0, 33'd0,          33'd0);
    run_op(32'd50,         11'h400, 1'b1, 33'd0,          33'd0);

    // A request pulsed mid-operation must be dropped
    @(negedge clk);
    operand = 32'd100; scale = 11'h400; valid_in = 1'b1;
    push(33'd100, 33'd100, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    operand = 32'd7; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_valid("ignored_pulse");
    repeat (15) @(negedge clk);
    chk("ignored_pulse_busy", 64'(b0), 64'd0);

    // valid_in held: second request accepted the edge after valid_out
    @(negedge clk);
    operand = 32'd1000; scale = 11'h200; valid_in = 1'b1;
    push(33'd500, 33'd500, 1'b0);
    @(negedge clk);
    operand = 32'd7; scale = 11'h600;
    push(33'd10, 33'd11, 1'b0);
    first = -1; second = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 8) valid_in = 1'b0;
      if (v0) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    chk("b2b_first_edge", 64'(first), 64'd7);
    chk("b2b_second_edge", 64'(second), 64'd15);

    // Reset mid-operation aborts it asynchronously
    @(negedge clk);
    operand = 32'd77; scale = 11'h400; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(b0), 64'd0);
    chk("async_rst_valid", 64'(v0), 64'd0);
    chk("async_rst_product", 64'(p0), 64'd0);
    chk("async_rst_product_r1", 64'(p1), 64'd0);
    chk("async_rst_err", 64'(e0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    operand = 32'd9; scale = 11'h400; valid_in = 1'b1;
    push(33'd9, 33'd9, 1'b0);
    @(negedge clk);
    chk("accept_after_reset", 64'(b0), 64'd1);
    valid_in = 1'b0;
    wait_valid("after_reset");
    repeat (20) @(negedge clk);

    chk("scoreboard_drained_r0", 64'(q0.size()), 64'd0);
    chk("scoreboard_drained_r1", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
